// File: rtl/md_pkg.sv
// ----------------------------------------------------------------------------
// md_pkg
// Shared definitions for the multiply/divide unit: md_op encodings used by
// the decoder, the hazard unit and md_unit, default latencies, and the FSM
// state type.
// ----------------------------------------------------------------------------
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_if.sv
// ----------------------------------------------------------------------------
// md_if
// E-stage bus into the multiply/divide unit.
//   start  : one-cycle launch pulse
//   md_op  : operation code (md_pkg::md_op_e values)
//   cancel : exception/interrupt this cycle, suppresses start
//   A, B   : forwarded rs / rt operands
//   busy   : operation in progress (registered)
//   HI, LO : architectural HI/LO registers
// master = E stage / pipeline side, slave = md_unit.
// ----------------------------------------------------------------------------
interface md_if;
    logic        start;
    logic [2:0]  md_op;
    logic        cancel;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, md_op, cancel, A, B,
        input  busy, HI, LO
    );

    modport slave (
        input  start, md_op, cancel, A, B,
        output busy, HI, LO
    );
endinterface

// File: rtl/md_calc.sv
// ----------------------------------------------------------------------------
// md_calc
// Purely combinational arithmetic for the multiply/divide unit.
//   a_i, b_i       : operands (rs, rt)
//   md_op_i        : operation code
//   res_hi_o       : product[63:32] or remainder
//   res_lo_o       : product[31:0]  or quotient
//   div_by_zero_o  : div/divu with b_i == 0 (result must not be committed)
// ----------------------------------------------------------------------------
module md_calc
    import md_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  md_op_i,
    output logic [31:0] res_hi_o,
    output logic [31:0] res_lo_o,
    output logic        div_by_zero_o
);

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               b_zero;
    logic               div_ovf;
    logic signed [31:0] a_s;
    logic signed [31:0] b_sdiv;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] b_udiv;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;

    assign a_sx   = {{32{a_i[31]}}, a_i};
    assign b_sx   = {{32{b_i[31]}}, b_i};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a_i} * {32'd0, b_i};

    // A zero divisor is replaced by 1 so the divider never sees x-producing
    // input; the result is discarded via div_by_zero_o anyway.
    // 0x80000000 / -1 overflows; dividing by 1 instead yields exactly the
    // architected answer (quotient 0x80000000, remainder 0).
    assign b_zero  = (b_i == 32'd0);
    assign div_ovf = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    assign a_s     = $signed(a_i);
    assign b_sdiv  = (b_zero || div_ovf) ? 32'sd1 : $signed(b_i);
    assign quo_s   = a_s / b_sdiv;
    assign rem_s   = a_s % b_sdiv;
    assign b_udiv  = b_zero ? 32'd1 : b_i;
    assign quo_u   = a_i / b_udiv;
    assign rem_u   = a_i % b_udiv;

    always_comb begin
        res_hi_o      = 32'd0;
        res_lo_o      = 32'd0;
        div_by_zero_o = 1'b0;
        case (md_op_i)
            MD_MULT: begin
                res_hi_o = prod_s[63:32];
                res_lo_o = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi_o = prod_u[63:32];
                res_lo_o = prod_u[31:0];
            end
            MD_DIV: begin
                res_hi_o      = rem_s;
                res_lo_o      = quo_s;
                div_by_zero_o = b_zero;
            end
            MD_DIVU: begin
                res_hi_o      = rem_u;
                res_lo_o      = quo_u;
                div_by_zero_o = b_zero;
            end
            default: begin
                res_hi_o      = 32'd0;
                res_lo_o      = 32'd0;
                div_by_zero_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// ----------------------------------------------------------------------------
// md_unit
// E-stage multiply/divide unit holding architectural HI/LO.
// mult/multu/div/divu compute their result at launch, park it in pending
// registers, and commit it to HI/LO after MULT_CYCLES/DIV_CYCLES busy cycles.
// mthi/mtlo write HI/LO directly at the launch edge.
// Ports:
//   clk    : clock, all state updates on rising edge
//   reset  : synchronous active-high reset
//   md_bus : md_if.slave (start, md_op, cancel, A, B -> busy, HI, LO)
// ----------------------------------------------------------------------------
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)
(
    input  logic clk,
    input  logic reset,
    md_if.slave  md_bus
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     pend_hi_q, pend_hi_d;
    logic [31:0]     pend_lo_q, pend_lo_d;
    logic            pend_dbz_q, pend_dbz_d;

    logic [31:0]     calc_hi;
    logic [31:0]     calc_lo;
    logic            calc_dbz;
    logic            accept;

    md_calc u_calc (
        .a_i           (md_bus.A),
        .b_i           (md_bus.B),
        .md_op_i       (md_bus.md_op),
        .res_hi_o      (calc_hi),
        .res_lo_o      (calc_lo),
        .div_by_zero_o (calc_dbz)
    );

    // A start is only honoured from IDLE; cancel kills it outright.
    assign accept = md_bus.start && !md_bus.cancel;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        pend_hi_d  = pend_hi_q;
        pend_lo_d  = pend_lo_q;
        pend_dbz_d = pend_dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (md_bus.md_op)
                        MD_MULT, MD_MULTU: begin
                            pend_hi_d  = calc_hi;
                            pend_lo_d  = calc_lo;
                            pend_dbz_d = 1'b0;
                            cnt_d      = MULT_LOAD;
                            state_d    = ST_BUSY;
                        end
                        MD_DIV, MD_DIVU: begin
                            pend_hi_d  = calc_hi;
                            pend_lo_d  = calc_lo;
                            pend_dbz_d = calc_dbz;
                            cnt_d      = DIV_LOAD;
                            state_d    = ST_BUSY;
                        end
                        MD_MTHI: hi_d = md_bus.A;
                        MD_MTLO: lo_d = md_bus.A;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                // Commit on the edge where the counter leaves 1, so busy is
                // high for exactly the loaded number of cycles.
                if (cnt_q == CNT_ONE) begin
                    if (!pend_dbz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            pend_hi_q  <= 32'd0;
            pend_lo_q  <= 32'd0;
            pend_dbz_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            pend_hi_q  <= pend_hi_d;
            pend_lo_q  <= pend_lo_d;
            pend_dbz_q <= pend_dbz_d;
        end
    end

    assign md_bus.busy = (state_q == ST_BUSY);
    assign md_bus.HI   = hi_q;
    assign md_bus.LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// ----------------------------------------------------------------------------
// tb_md_unit
// Self-checking bench for md_unit: directed cases plus randomized operation
// streams compared against a behavioural HI/LO model using 64-bit arithmetic.
// ----------------------------------------------------------------------------
module tb_md_unit;
    import md_pkg::*;

    localparam int NM = 5;
    localparam int ND = 10;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    md_if bus ();

    md_unit #(
        .MULT_CYCLES (NM),
        .DIV_CYCLES  (ND)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .md_bus (bus)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural reference: what HI/LO become and how long busy lasts.
    function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output int lat, output bit wr_hi, output bit wr_lo,
                                   output logic [31:0] hi, output logic [31:0] lo);
        longint          sp;
        longint unsigned up;
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        lat = 0; wr_hi = 0; wr_lo = 0; hi = 32'd0; lo = 32'd0;
        case (op)
            3'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                hi = sp[63:32]; lo = sp[31:0];
                lat = NM; wr_hi = 1; wr_lo = 1;
            end
            3'd2: begin
                up = 64'(a) * 64'(b);
                hi = up[63:32]; lo = up[31:0];
                lat = NM; wr_hi = 1; wr_lo = 1;
            end
            3'd3: begin
                lat = ND;
                if (b != 32'd0) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q = sa / sb;
                    r = sa % sb;
                    lo = q[31:0]; hi = r[31:0];
                    wr_hi = 1; wr_lo = 1;
                end
            end
            3'd4: begin
                lat = ND;
                if (b != 32'd0) begin
                    lo = a / b; hi = a % b;
                    wr_hi = 1; wr_lo = 1;
                end
            end
            3'd5: begin hi = a; wr_hi = 1; end
            3'd6: begin lo = a; wr_lo = 1; end
            default: ;
        endcase
    endfunction

    // Launch one op at the current negedge; optionally inject a start/cancel
    // in busy cycle inj_at (1 = first busy cycle). Ends at the negedge of the
    // first non-busy cycle after checking latency and HI/LO.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit cxl, input int inj_at,
                          input bit inj_start, input bit inj_cxl);
        int          lat;
        bit          wh;
        bit          wl;
        logic [31:0] rh;
        logic [31:0] rl;
        int          cnt;
        ref_op(op, a, b, lat, wh, wl, rh, rl);
        if (cxl) begin lat = 0; wh = 0; wl = 0; end
        bus.start = 1'b1; bus.md_op = op; bus.A = a; bus.B = b; bus.cancel = cxl;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.md_op = MD_NONE; bus.cancel = 1'b0;
        bus.A = $urandom; bus.B = $urandom;
        cnt = 0;
        while (bus.busy && cnt < 64) begin
            cnt++;
            if (cnt == inj_at) begin
                bus.start = inj_start; bus.md_op = MD_MTLO;
                bus.A = $urandom; bus.cancel = inj_cxl;
            end
            @(negedge clk);
            bus.start = 1'b0; bus.md_op = MD_NONE; bus.cancel = 1'b0;
        end
        if (wh) exp_hi = rh;
        if (wl) exp_lo = rl;
        chk({tag, "_lat"}, 32'(cnt), 32'(lat));
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_hi"}, bus.HI, exp_hi);
        chk({tag, "_lo"}, bus.LO, exp_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.start = 1'b0; bus.md_op = MD_NONE; bus.cancel = 1'b0;
        bus.A = 32'd0; bus.B = 32'd0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_hi", bus.HI, 32'd0);
            chk("rst_lo", bus.LO, 32'd0);
        end

        run_op("mult", MD_MULT, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 0);
        chk("mult_hi_k", bus.HI, 32'hFFFF_FFFF);
        chk("mult_lo_k", bus.LO, 32'hFFFF_FFFE);

        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 0);
        chk("multu_hi_k", bus.HI, 32'h0000_0001);
        chk("multu_lo_k", bus.LO, 32'hFFFF_FFFE);

        run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0);
        chk("div_hi_k", bus.HI, 32'hFFFF_FFFF);
        chk("div_lo_k", bus.LO, 32'hFFFF_FFFD);

        run_op("divu0", MD_DIVU, 32'd7, 32'd0, 0, 0, 0, 0);
        chk("divu0_hi_k", bus.HI, 32'hFFFF_FFFF);
        chk("divu0_lo_k", bus.LO, 32'hFFFF_FFFD);

        run_op("mthi", MD_MTHI, 32'h1234_5678, 32'd0, 0, 0, 0, 0);
        chk("mthi_k", bus.HI, 32'h1234_5678);
        run_op("mthi_cxl", MD_MTHI, 32'hDEAD_BEEF, 32'd0, 1, 0, 0, 0);
        chk("mthi_cxl_k", bus.HI, 32'h1234_5678);
        run_op("mtlo", MD_MTLO, 32'hCAFE_0001, 32'd0, 0, 0, 0, 0);

        run_op("mult_inj", MD_MULT, 32'd1000, 32'hFFFF_FFFD, 0, 3, 1, 0);
        chk("mult_inj_lo_k", bus.LO, 32'hFFFF_F448);
        run_op("mult_cxl", MD_MULTU, 32'h0001_0000, 32'h0001_0000, 0, 2, 0, 1);
        chk("mult_cxl_hi_k", bus.HI, 32'h0000_0001);
        run_op("div_cxl", MD_DIV, 32'd100, 32'd7, 1, 0, 0, 0);

        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
        chk("div_ovf_lo_k", bus.LO, 32'h8000_0000);
        chk("div_ovf_hi_k", bus.HI, 32'd0);

        // Reset in the fourth busy cycle of a divide.
        bus.start = 1'b1; bus.md_op = MD_DIV; bus.A = 32'd100; bus.B = 32'd7; bus.cancel = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.md_op = MD_NONE;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        chk("rstmid_busy", 32'(bus.busy), 32'd0);
        chk("rstmid_hi", bus.HI, 32'd0);
        chk("rstmid_lo", bus.LO, 32'd0);
        repeat (12) @(negedge clk);
        chk("rstmid_late_busy", 32'(bus.busy), 32'd0);
        chk("rstmid_late_hi", bus.HI, 32'd0);
        chk("rstmid_late_lo", bus.LO, 32'd0);

        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 6));
            run_op("rnd", op, pick(), pick(), ($urandom_range(0, 7) == 0),
                   $urandom_range(0, 12), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
